// File: rtl/usart_pkg.sv
// Shared types and helpers for the USART transmitter.
// The PARITY state exists only when USART_TX_PARITY_EN is defined.
package usart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef USART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

  // Integer divide: any fractional remainder is dropped.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/usart_tx_fifo.sv
// Synchronous transmit FIFO with full/empty tracking and a registered ready flag.
// ready mirrors "not full" for the next occupancy, so it is held low in reset.
module usart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             ready,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  // Acceptance uses the registered ready, which reflects the occupancy before any same-cycle pop.
  assign do_push  = push && ready_q;
  assign do_pop   = pop && (count_q != '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign ready    = ready_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: rtl/usart_tx.sv
// Buffered USART transmitter: start bit, DATA_BIT data bits LSB first, stop bit.
// Define USART_TX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1).
module usart_tx
  import usart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BIT   = 8,
  parameter int FIFO_DEPTH = 4
`ifdef USART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W        = $clog2(DATA_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);
`ifdef USART_TX_PARITY_EN
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BIT) - 1);
`endif

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             fifo_pop, fifo_empty, fifo_ready, bit_done;
  logic [7:0]       fifo_data;
`ifdef USART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  usart_tx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_valid),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .ready    (fifo_ready),
    .empty    (fifo_empty)
  );

  assign bit_done = (cnt_q == LAST_CNT);
  assign tx_ready = fifo_ready;
  assign tx       = tx_q;
  assign busy     = busy_q;

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;
`ifdef USART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef USART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef USART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (bit_done) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fifo_pop) begin
      shift_d = fifo_data;
`ifdef USART_TX_PARITY_EN
      parity_d = (^(fifo_data & DATA_MASK)) ^ (PARITY_ODD != 0);
`endif
    end
    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef USART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef USART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_usart_tx.sv
// Directed self-checking bench for usart_tx: a default-rate instance plus a
// fast 5-bit instance; parity instances are added when USART_TX_PARITY_EN is defined.
module tb_usart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_data, s_data;
  logic       d_valid, d_ready, d_tx, d_busy;
  logic       s_valid, s_ready, s_tx, s_busy;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  usart_tx dut (
    .clk(clk), .reset(reset), .tx_data(d_data), .tx_valid(d_valid),
    .tx_ready(d_ready), .tx(d_tx), .busy(d_busy)
  );

  usart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BIT(5)) dut5 (
    .clk(clk), .reset(reset), .tx_data(s_data), .tx_valid(s_valid),
    .tx_ready(s_ready), .tx(s_tx), .busy(s_busy)
  );

`ifdef USART_TX_PARITY_EN
  logic [7:0] p_data, o_data;
  logic       p_valid, p_ready, p_tx, p_busy;
  logic       o_valid, o_ready, o_tx, o_busy;

  usart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_ODD(0)) dutp (
    .clk(clk), .reset(reset), .tx_data(p_data), .tx_valid(p_valid),
    .tx_ready(p_ready), .tx(p_tx), .busy(p_busy)
  );

  usart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_ODD(1)) duto (
    .clk(clk), .reset(reset), .tx_data(o_data), .tx_valid(o_valid),
    .tx_ready(o_ready), .tx(o_tx), .busy(o_busy)
  );
`endif

  function automatic logic line_tx(input int which);
    case (which)
      0: return d_tx;
      1: return s_tx;
`ifdef USART_TX_PARITY_EN
      2: return p_tx;
      3: return o_tx;
`endif
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic line_busy(input int which);
    case (which)
      0: return d_busy;
      1: return s_busy;
`ifdef USART_TX_PARITY_EN
      2: return p_busy;
      3: return o_busy;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples the middle and last cycle of each line bit; offset is cycles already spent in bit 0.
  task automatic grab(input int which, input int cpb, input int nbits, input int offset,
                      output logic [63:0] mid_v, output logic [63:0] end_v,
                      output logic busy_last);
    int pos = offset;
    mid_v     = '0;
    end_v     = '0;
    busy_last = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      while (pos < b * cpb + cpb / 2) begin step(); pos++; end
      mid_v[b] = line_tx(which);
      while (pos < b * cpb + cpb - 1) begin step(); pos++; end
      end_v[b]  = line_tx(which);
      busy_last = line_busy(which);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    d_valid = 1'b0; d_data = '0;
    s_valid = 1'b0; s_data = '0;
`ifdef USART_TX_PARITY_EN
    p_valid = 1'b0; p_data = '0;
    o_valid = 1'b0; o_data = '0;
`endif
    repeat (3) step();
    checks++; if (d_tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b expected 1", d_tx); end
    checks++; if (d_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", d_ready); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", d_busy); end
    checks++; if (s_tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx5: got %b expected 1", s_tx); end
    reset = 1'b1;
    checks++; if (d_ready !== 1'b0) begin failures++; $display("[TB] FAIL release_ready_early: got %b expected 0", d_ready); end
    step();
    checks++; if (d_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_ready: got %b expected 1", d_ready); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_ready5: got %b expected 1", s_ready); end
  endtask

  task automatic test_single_frame();
    logic [63:0] mid_v, end_v;
    logic        busy_last;
    logic [9:0]  exp_v = {1'b1, 8'h55, 1'b0};
    d_data = 8'h55; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    checks++; if (d_tx !== 1'b1) begin failures++; $display("[TB] FAIL single_tx_k: got %b expected 1", d_tx); end
    step();
    checks++; if (d_tx !== 1'b1) begin failures++; $display("[TB] FAIL single_tx_k1: got %b expected 1", d_tx); end
    checks++; if (d_busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_k1: got %b expected 1", d_busy); end
    step();
    checks++; if (d_tx !== 1'b0) begin failures++; $display("[TB] FAIL single_start_k2: got %b expected 0", d_tx); end
    grab(0, 868, 10, 0, mid_v, end_v, busy_last);
    checks++; if (mid_v[9:0] !== exp_v) begin failures++; $display("[TB] FAIL single_mid_bits: got %b expected %b", mid_v[9:0], exp_v); end
    checks++; if (end_v[9:0] !== exp_v) begin failures++; $display("[TB] FAIL single_end_bits: got %b expected %b", end_v[9:0], exp_v); end
    checks++; if (busy_last !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_stop: got %b expected 1", busy_last); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after: got %b expected 0", d_busy); end
    checks++; if (d_tx !== 1'b1) begin failures++; $display("[TB] FAIL single_idle_tx: got %b expected 1", d_tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [39:0] exp_v = {1'b1, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0,
                          1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    logic [63:0] mid_v, end_v;
    logic        busy_last;
    for (int i = 0; i < 4; i++) begin
      d_data = words[i]; d_valid = 1'b1;
      checks++; if (d_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", i, d_ready); end
      step();
      if (i == 2) begin
        checks++; if (d_tx !== 1'b0) begin failures++; $display("[TB] FAIL b2b_start: got %b expected 0", d_tx); end
      end
    end
    d_valid = 1'b0;
    checks++; if (d_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_after: got %b expected 1", d_ready); end
    grab(0, 868, 40, 1, mid_v, end_v, busy_last);
    checks++; if (mid_v[39:0] !== exp_v) begin failures++; $display("[TB] FAIL b2b_mid_bits: got %h expected %h", mid_v[39:0], exp_v); end
    checks++; if (end_v[39:0] !== exp_v) begin failures++; $display("[TB] FAIL b2b_end_bits: got %h expected %h", end_v[39:0], exp_v); end
    checks++; if (busy_last !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy_stop: got %b expected 1", busy_last); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_after: got %b expected 0", d_busy); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0]  words [6] = '{8'hE1, 8'h32, 8'h0C, 8'h9F, 8'h15, 8'h0A};
    logic [34:0] exp_v;
    logic [63:0] mid_v, end_v;
    logic        busy_last;
    int          lows = 0;
    for (int i = 0; i < 5; i++) exp_v[7*i +: 7] = {1'b1, words[i][4:0], 1'b0};
    for (int i = 0; i < 6; i++) begin
      s_data = words[i]; s_valid = 1'b1;
      checks++; if (s_ready !== (i < 5)) begin failures++; $display("[TB] FAIL fill_ready_%0d: got %b expected %b", i, s_ready, (i < 5)); end
      step();
    end
    s_valid = 1'b0;
    grab(1, 10, 35, 3, mid_v, end_v, busy_last);
    checks++; if (mid_v[34:0] !== exp_v) begin failures++; $display("[TB] FAIL fill_mid_bits: got %h expected %h", mid_v[34:0], exp_v); end
    checks++; if (end_v[34:0] !== exp_v) begin failures++; $display("[TB] FAIL fill_end_bits: got %h expected %h", end_v[34:0], exp_v); end
    checks++; if (s_busy !== 1'b0) begin failures++; $display("[TB] FAIL fill_busy_after: got %b expected 0", s_busy); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_ready_after: got %b expected 1", s_ready); end
    repeat (30) begin
      if (s_tx !== 1'b1) lows++;
      step();
    end
    checks++; if (lows !== 0) begin failures++; $display("[TB] FAIL fill_no_sixth_frame: got %0d low cycles expected 0", lows); end
  endtask

  task automatic test_data_bits5();
    logic [6:0]  exp_v = {1'b1, 5'b11111, 1'b0};
    logic [63:0] mid_v, end_v;
    logic        busy_last;
    s_data = 8'hFF; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    step();
    checks++; if (s_tx !== 1'b0) begin failures++; $display("[TB] FAIL d5_start: got %b expected 0", s_tx); end
    grab(1, 10, 7, 0, mid_v, end_v, busy_last);
    checks++; if (mid_v[6:0] !== exp_v) begin failures++; $display("[TB] FAIL d5_mid_bits: got %b expected %b", mid_v[6:0], exp_v); end
    checks++; if (end_v[6:0] !== exp_v) begin failures++; $display("[TB] FAIL d5_end_bits: got %b expected %b", end_v[6:0], exp_v); end
    checks++; if (s_busy !== 1'b0) begin failures++; $display("[TB] FAIL d5_busy_after: got %b expected 0", s_busy); end
  endtask

`ifdef USART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] exp_even = {1'b1, 1'b1, 8'h07, 1'b0};
    logic [10:0] exp_odd  = {1'b1, 1'b0, 8'h07, 1'b0};
    logic [63:0] mid_v, end_v;
    logic        busy_last;
    p_data = 8'h07; p_valid = 1'b1;
    step();
    p_valid = 1'b0;
    step();
    step();
    grab(2, 10, 11, 0, mid_v, end_v, busy_last);
    checks++; if (mid_v[10:0] !== exp_even) begin failures++; $display("[TB] FAIL parity_even_bits: got %b expected %b", mid_v[10:0], exp_even); end
    checks++; if (end_v[10:0] !== exp_even) begin failures++; $display("[TB] FAIL parity_even_end: got %b expected %b", end_v[10:0], exp_even); end
    checks++; if (p_busy !== 1'b0) begin failures++; $display("[TB] FAIL parity_even_busy: got %b expected 0", p_busy); end
    o_data = 8'h07; o_valid = 1'b1;
    step();
    o_valid = 1'b0;
    step();
    step();
    grab(3, 10, 11, 0, mid_v, end_v, busy_last);
    checks++; if (mid_v[10:0] !== exp_odd) begin failures++; $display("[TB] FAIL parity_odd_bits: got %b expected %b", mid_v[10:0], exp_odd); end
    checks++; if (end_v[10:0] !== exp_odd) begin failures++; $display("[TB] FAIL parity_odd_end: got %b expected %b", end_v[10:0], exp_odd); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int lows = 0;
    int busys = 0;
    d_data = 8'h0F; d_valid = 1'b1;
    step();
    d_data = 8'h00;
    step();
    d_valid = 1'b0;
    step();
    checks++; if (d_tx !== 1'b0) begin failures++; $display("[TB] FAIL rst_start: got %b expected 0", d_tx); end
    repeat (3000) step();
    checks++; if (d_busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_busy_before: got %b expected 1", d_busy); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (d_tx !== 1'b1) begin failures++; $display("[TB] FAIL rst_async_tx: got %b expected 1", d_tx); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_busy: got %b expected 0", d_busy); end
    checks++; if (d_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_ready: got %b expected 0", d_ready); end
    step();
    reset = 1'b1;
    step();
    checks++; if (d_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready: got %b expected 1", d_ready); end
    repeat (10000) begin
      if (d_tx !== 1'b1) lows++;
      if (d_busy !== 1'b0) busys++;
      step();
    end
    checks++; if (lows !== 0) begin failures++; $display("[TB] FAIL rst_no_frame: got %0d low cycles expected 0", lows); end
    checks++; if (busys !== 0) begin failures++; $display("[TB] FAIL rst_busy_idle: got %0d busy cycles expected 0", busys); end
  endtask

  initial begin
    $display("[TB] usart_tx directed tests starting");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fill_overflow();
    test_data_bits5();
`ifdef USART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usart_tx.md
USART_TX -- requirements
Module: usart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BIT, default 8, data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries, power of two, minimum 2.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset: asserted low at any time, released synchronously to clk.
REQ-007 SHALL have port tx_data, input, 8, byte to send; only bits [DATA_BIT-1:0] are transmitted.
REQ-008 SHALL have port tx_valid, input, 1, tx_data is valid this cycle.
REQ-009 SHALL have port tx_ready, output, 1, the buffer can accept a word this cycle.
REQ-010 SHALL have port tx, output, 1, serial line, idle high, driven from a register.
REQ-011 SHALL have port busy, output, 1, high while a frame is on the line or the buffer is non-empty.

Function
REQ-012 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide, 868 at defaults); every line bit is held for exactly CLKS_PER_BIT cycles.
REQ-013 SHALL accept a word on the edge where tx_valid && tx_ready, with no combinational path from tx_valid to tx_ready.
REQ-014 SHALL drive tx_ready = !full and evaluate it before any same-cycle pop, so a full buffer never accepts, even while popping.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP: IDLE->START when the buffer is non-empty (pop); START->DATA after one bit time; DATA->PARITY or STOP after DATA_BIT bit times; PARITY->STOP after one bit time; STOP->START if the buffer is non-empty, else IDLE.
REQ-016 SHALL send the start bit as 0, data LSB first, and the stop bit as 1.
REQ-017 SHALL drive tx low from edge k+2 when a word is accepted at edge k into an empty buffer with the FSM in IDLE.
REQ-018 SHALL send back-to-back frames with no idle gap: the next start bit immediately follows a full-length stop bit.
REQ-019 SHALL handle a simultaneous push and pop correctly, keeping the occupancy count unchanged and preserving order.
REQ-020 SHALL ignore tx_valid while tx_ready is low; the word is not stored and no error is flagged.
REQ-021 SHALL keep the bit-time counter and bit index wide enough for CLKS_PER_BIT and DATA_BIT, with no wrap-around inside a frame.

Reset
REQ-022 SHALL, while reset is low, force: tx=1, tx_ready=0, busy=0, FSM=IDLE, counters=0, buffer empty.
REQ-023 SHALL, on reset mid-frame, abort the frame immediately with tx=1 and discard all buffered words.
REQ-024 SHALL raise tx_ready on the first edge after reset release.

Configuration
REQ-025 SHALL, when macro USART_TX_PARITY_EN is defined, insert one parity bit after the data bits; parameter PARITY_ODD (default 0) selects even (0) or odd (1) parity over the DATA_BIT bits.
REQ-026 SHALL, when USART_TX_PARITY_EN is undefined, omit the PARITY state and the PARITY_ODD parameter, giving a frame of 1+DATA_BIT+1 bits.

Structure
REQ-027 SHALL place the FSM state enum and a CLKS_PER_BIT calculation function in the shared package usart_pkg.
REQ-028 SHALL implement the buffer as the sub-module usart_tx_fifo (synchronous FIFO with full/empty flags), instantiated once.

Verification
REQ-029 SHALL check a single 0x55 sent from idle at defaults: tx low at k+2, then bits 1,0,1,0,1,0,1,0, then 1; frame length 8680 cycles; busy falls after the stop bit.
REQ-030 SHALL check that pushing 0xA5, 0x3C, 0xFF, 0x00 back-to-back produces 4 contiguous frames (34720 cycles) with no idle gap; tx_ready never drops with FIFO_DEPTH=4 because one word is popped first.
REQ-031 SHALL check that holding tx_valid for 6 words while idle stores only FIFO_DEPTH+1 words, and tx_ready deasserts on the cycle the buffer reaches full.
REQ-032 SHALL check that asserting reset at cycle 3000 of a 0x0F frame returns tx to 1 asynchronously, that no further frame appears, and that busy=0.
REQ-033 SHALL check, with USART_TX_PARITY_EN defined and PARITY_ODD=0, that 0x07 yields parity bit 1 and a frame of 11 bit times; with PARITY_ODD=1 the parity bit is 0.
REQ-034 SHALL check that DATA_BIT=5 with tx_data=0xFF sends 5 ones and a frame of 7 bit times, with bits [7:5] ignored.
